spi_burst_master: RTL and testbench

Bus-master sequencer that sits directly upstream of the SPI controller and drives its register port (MST_CEn/ADDR/WDATA/WEn/RDATA). It accepts a burst command plus byte streams on both sides. It configures the controller, keeps its 4-deep Tx FIFO fed, drains its 4-deep Rx FIFO, and signals completion. This lets a streaming client run multi-byte SPI transfers without software polling.

---
 rtl/spi_ctrl_defs.sv | 54 +++++
 rtl/spi_burst_master_if.sv | 49 ++++
 rtl/spi_burst_master.sv | 175 +++++++++++++++++
 tb/tb_spi_burst_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_defs.sv
// spi_ctrl_defs: register map, bit positions, FSM encoding and bus helpers
// shared by the SPI burst master and anything that talks to the controller.
package spi_ctrl_defs;

  localparam logic [31:0] A_SPCR = 32'h00;
  localparam logic [31:0] A_SPSR = 32'h04;
  localparam logic [31:0] A_SCDR = 32'h0C;
  localparam logic [31:0] A_SPDR = 32'h10;
  localparam logic [31:0] A_SDRR = 32'h14;

  localparam int SPCR_EN    = 6;
  localparam int SPCR_IE    = 7;
  localparam int SPCR_CPOL  = 3;
  localparam int SPCR_CPHA  = 2;
  localparam int SPCR_SS_LO = 8;

  localparam int SPSR_RXE = 0;
  localparam int SPSR_RXF = 1;
  localparam int SPSR_TXE = 2;
  localparam int SPSR_TXF = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_DIV, S_CFG_CTRL, S_GAP, S_POLL_REQ, S_POLL_WAIT,
    S_PUSH, S_POP_REQ, S_POP_WAIT, S_RX_HOLD, S_DISABLE, S_DONE
  } state_t;

  typedef struct packed {
    logic        cen;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  // SPCR image; interrupts are never enabled and TCNT stays 0
  function automatic logic [31:0] spcr_val(logic en, logic [1:0] ss, logic cpol, logic cpha);
    logic [31:0] v;
    v = '0;
    v[SPCR_EN]             = en;
    v[SPCR_IE]             = 1'b0;
    v[SPCR_CPOL]           = cpol;
    v[SPCR_CPHA]           = cpha;
    v[SPCR_SS_LO +: 2]     = ss;
    return v;
  endfunction

  function automatic bus_t bus_wr(logic [31:0] a, logic [31:0] d);
    return '{cen: 1'b0, wen: 1'b0, addr: a, wdata: d};
  endfunction

  function automatic bus_t bus_rd(logic [31:0] a);
    return '{cen: 1'b0, wen: 1'b1, addr: a, wdata: 32'h0};
  endfunction

endpackage

// File: rtl/spi_burst_master_if.sv
// spi_burst_master_if: command, byte streams, status and controller bus of
// the burst master. err exists only when SPI_BURST_TIMEOUT_EN is defined.
interface spi_burst_master_if;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_ss;
  logic        cmd_cpol, cmd_cpha;
  logic [15:0] cmd_div;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        done, busy;
`ifdef SPI_BURST_TIMEOUT_EN
  logic        err;
`endif
  logic        mst_cen, mst_wen;
  logic [31:0] mst_addr, mst_wdata, mst_rdata;

  modport master (
    input  cmd_valid, cmd_len, cmd_ss, cmd_cpol, cmd_cpha, cmd_div,
    output cmd_ready,
    input  tx_valid, tx_data,
    output tx_ready,
    output rx_valid, rx_data,
    input  rx_ready,
    output done, busy,
`ifdef SPI_BURST_TIMEOUT_EN
    output err,
`endif
    output mst_cen, mst_wen, mst_addr, mst_wdata,
    input  mst_rdata
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_ss, cmd_cpol, cmd_cpha, cmd_div,
    input  cmd_ready,
    output tx_valid, tx_data,
    input  tx_ready,
    input  rx_valid, rx_data,
    output rx_ready,
    input  done, busy,
`ifdef SPI_BURST_TIMEOUT_EN
    input  err,
`endif
    input  mst_cen, mst_wen, mst_addr, mst_wdata,
    output mst_rdata
  );
endinterface

// File: rtl/spi_burst_master.sv
// spi_burst_master: drives the SPI controller register port to run a burst
// of CMD_LEN bytes, feeding its Tx FIFO from the tx stream and draining its
// Rx FIFO into the rx stream. Define SPI_BURST_TIMEOUT_EN for a 16-bit
// no-progress watchdog that abandons the burst and pulses err with done.
module spi_burst_master
  import spi_ctrl_defs::*;
#(
  parameter int POLL_GAP     = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               reset,
  spi_burst_master_if.master sif
);

  state_t     state;
  bus_t       mbus;
  logic [7:0] len, pushed, popped, gap_cnt, rx_data;
  logic [1:0] ss;
  logic       cpol, cpha, tx_ready, rx_valid, done;
  logic [8:0] inflight;
  logic       rx_empty, tx_full;
  logic       unused_rdata;

  // 9-bit difference so pushed-popped can never wrap
  assign inflight     = {1'b0, pushed} - {1'b0, popped};
  assign rx_empty     = sif.mst_rdata[SPSR_RXE];
  assign tx_full      = sif.mst_rdata[SPSR_TXF];
  assign unused_rdata = ^sif.mst_rdata[31:8];

  assign sif.cmd_ready = (state == S_IDLE);
  assign sif.busy      = (state != S_IDLE);
  assign sif.tx_ready  = tx_ready;
  assign sif.rx_valid  = rx_valid;
  assign sif.rx_data   = rx_data;
  assign sif.done      = done;
  assign sif.mst_cen   = mbus.cen;
  assign sif.mst_wen   = mbus.wen;
  assign sif.mst_addr  = mbus.addr;
  assign sif.mst_wdata = mbus.wdata;

`ifdef SPI_BURST_TIMEOUT_EN
  logic [15:0] wd;
  logic        abort, err, timeout;

  // only abandon from the waiting states so no bus write is cut short
  assign timeout = (wd == 16'hFFFF) &&
                   (state inside {S_GAP, S_POLL_REQ, S_POLL_WAIT, S_RX_HOLD});
  assign sif.err = err;

  // cycles since the last push or pop; saturates at all-ones
  always_ff @(posedge clk) begin
    if (reset)                                                        wd <= '0;
    else if (state == S_IDLE || state == S_PUSH || state == S_POP_WAIT) wd <= '0;
    else if (wd != 16'hFFFF)                                          wd <= wd + 16'd1;
  end
`endif

  // burst sequencer; bus outputs are loaded on entry to the state that owns the access
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mbus     <= '{cen: 1'b1, wen: 1'b1, addr: 32'h0, wdata: 32'h0};
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
      len      <= '0;
      pushed   <= '0;
      popped   <= '0;
      gap_cnt  <= '0;
      ss       <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
      abort    <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      mbus.cen <= 1'b1;
      mbus.wen <= 1'b1;
      tx_ready <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
      err      <= 1'b0;
`endif
      case (state)
        S_IDLE: if (sif.cmd_valid) begin
          len    <= sif.cmd_len;
          ss     <= sif.cmd_ss;
          cpol   <= sif.cmd_cpol;
          cpha   <= sif.cmd_cpha;
          pushed <= '0;
          popped <= '0;
`ifdef SPI_BURST_TIMEOUT_EN
          abort  <= 1'b0;
`endif
          if (sif.cmd_len == 8'd0) state <= S_DONE;
          else begin
            state <= S_CFG_DIV;
            mbus  <= bus_wr(A_SCDR, {16'h0, sif.cmd_div});
          end
        end
        S_CFG_DIV: begin
          state <= S_CFG_CTRL;
          mbus  <= bus_wr(A_SPCR, spcr_val(1'b1, ss, cpol, cpha));
        end
        S_CFG_CTRL: begin
          state   <= S_GAP;
          gap_cnt <= '0;
        end
        S_GAP: begin
          if (gap_cnt == 8'(POLL_GAP - 1)) begin
            state <= S_POLL_REQ;
            mbus  <= bus_rd(A_SPSR);
          end else gap_cnt <= gap_cnt + 8'd1;
        end
        S_POLL_REQ: state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (!rx_empty && popped < len) begin
            state <= S_POP_REQ;
            mbus  <= bus_rd(A_SDRR);
          end else if (pushed < len && sif.tx_valid && !tx_full &&
                       inflight < 9'(MAX_INFLIGHT)) begin
            state    <= S_PUSH;
            tx_ready <= 1'b1;
            mbus     <= bus_wr(A_SPDR, {24'h0, sif.tx_data});
          end else if (popped == len) begin
            state <= S_DISABLE;
            mbus  <= bus_wr(A_SPCR, spcr_val(1'b0, ss, cpol, cpha));
          end else begin
            state <= S_POLL_REQ;
            mbus  <= bus_rd(A_SPSR);
          end
        end
        S_PUSH: begin
          pushed  <= pushed + 8'd1;
          state   <= S_GAP;
          gap_cnt <= '0;
        end
        S_POP_REQ: state <= S_POP_WAIT;
        S_POP_WAIT: begin
          rx_data  <= sif.mst_rdata[7:0];
          rx_valid <= 1'b1;
          popped   <= popped + 8'd1;
          state    <= S_RX_HOLD;
        end
        S_RX_HOLD: if (sif.rx_ready) begin
          rx_valid <= 1'b0;
          state    <= S_GAP;
          gap_cnt  <= '0;
        end
        S_DISABLE: state <= S_DONE;
        S_DONE: begin
          done  <= 1'b1;
`ifdef SPI_BURST_TIMEOUT_EN
          err   <= abort;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef SPI_BURST_TIMEOUT_EN
      if (timeout) begin
        state    <= S_DISABLE;
        mbus     <= bus_wr(A_SPCR, spcr_val(1'b0, ss, cpol, cpha));
        tx_ready <= 1'b0;
        rx_valid <= 1'b0;
        abort    <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: directed bench with a loopback SPI controller model
// (4-deep Tx/Rx FIFOs, 16*(SCDR+1) cycles per byte). Bench stimulus and
// checks happen 1 time unit after posedge; the model and monitors run on
// negedge, when every signal holds its value for the coming edge.
module tb_spi_burst_master;
  import spi_ctrl_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_burst_master_if bus_if();
  spi_burst_master dut (.clk(clk), .reset(rst), .sif(bus_if));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // controller model state
  logic [31:0] m_spcr = '0, m_scdr = '0, st;
  logic [7:0]  m_txq[$], m_rxq[$], m_sh_byte;
  bit          m_sh_busy = 0;
  int          m_sh_cnt = 0, m_ovf = 0, m_unf = 0;

  // monitors and stream sources
  int          done_cnt = 0, err_with_done = 0, acc_cnt = 0, push_cnt = 0;
  int          inflight = 0, max_inflight = 0;
  logic [31:0] wr_a[$], wr_d[$];
  logic [7:0]  rx_got[$], tx_src[$];
  bit          tx_en = 1, rx_rdy_en = 1;

  // loopback controller plus bus/stream monitors
  always @(negedge clk) begin
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_sh_busy = 0;
    end else begin
      if (m_sh_busy) begin
        if (m_sh_cnt == 0) begin
          if (m_rxq.size() >= 4) m_ovf++;
          else m_rxq.push_back(m_sh_byte);
          m_sh_busy = 0;
        end else m_sh_cnt--;
      end else if (m_spcr[SPCR_EN] && m_txq.size() > 0) begin
        m_sh_byte = m_txq.pop_front();
        m_sh_busy = 1;
        m_sh_cnt  = 16 * (int'(m_scdr[15:0]) + 1) - 1;
      end
      if (!bus_if.mst_cen && !bus_if.mst_wen) begin
        wr_a.push_back(bus_if.mst_addr);
        wr_d.push_back(bus_if.mst_wdata);
        case (bus_if.mst_addr)
          A_SPCR: begin
            m_spcr = bus_if.mst_wdata;
            if (!m_spcr[SPCR_EN]) begin m_txq.delete(); m_rxq.delete(); m_sh_busy = 0; end
          end
          A_SCDR: m_scdr = bus_if.mst_wdata;
          A_SPDR: begin
            if (m_txq.size() >= 4) m_ovf++;
            else m_txq.push_back(bus_if.mst_wdata[7:0]);
            inflight++;
            if (inflight > max_inflight) max_inflight = inflight;
          end
          default: ;
        endcase
      end else if (!bus_if.mst_cen) begin
        if (bus_if.mst_addr == A_SPSR) begin
          st = '0;
          st[SPSR_RXE] = (m_rxq.size() == 0);
          st[SPSR_RXF] = (m_rxq.size() >= 4);
          st[SPSR_TXE] = (m_txq.size() == 0);
          st[SPSR_TXF] = (m_txq.size() >= 4);
          bus_if.mst_rdata = st;
        end else if (bus_if.mst_addr == A_SDRR) begin
          if (m_rxq.size() > 0) bus_if.mst_rdata = {24'h0, m_rxq.pop_front()};
          else m_unf++;
          inflight--;
        end
      end
    end
    if (!bus_if.mst_cen) acc_cnt++;
    if (bus_if.done) done_cnt++;
`ifdef SPI_BURST_TIMEOUT_EN
    if (bus_if.done && bus_if.err) err_with_done++;
`endif
    if (bus_if.rx_valid && bus_if.rx_ready) rx_got.push_back(bus_if.rx_data);
    if (bus_if.tx_valid && bus_if.tx_ready) begin
      push_cnt++;
      if (tx_src.size() > 0) void'(tx_src.pop_front());
    end
  end

  // stream inputs change just after the active edge
  always @(posedge clk) begin
    #1;
    bus_if.tx_valid = tx_en && (tx_src.size() > 0);
    bus_if.tx_data  = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
    bus_if.rx_ready = rx_rdy_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); rx_got.delete();
    acc_cnt = 0; push_cnt = 0; inflight = 0; max_inflight = 0; done_cnt = 0;
  endtask

  task automatic start(input logic [7:0] n, input logic [1:0] ss, input logic cpol,
                       input logic cpha, input logic [15:0] div);
    bus_if.cmd_len  = n;
    bus_if.cmd_ss   = ss;
    bus_if.cmd_cpol = cpol;
    bus_if.cmd_cpha = cpha;
    bus_if.cmd_div  = div;
    bus_if.cmd_valid = 1'b1;
    step();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin step(); n++; end
    chk(tag, done_cnt, target);
  endtask

  function automatic logic [31:0] wa(int i);
    return (i >= 0 && i < wr_a.size()) ? wr_a[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wd(int i);
    return (i >= 0 && i < wr_d.size()) ? wr_d[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] rg(int i);
    return (i < rx_got.size()) ? {24'h0, rx_got[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cen"},   bus_if.mst_cen, 1);
    chk({tag, "_wen"},   bus_if.mst_wen, 1);
    chk({tag, "_addr"},  bus_if.mst_addr, 0);
    chk({tag, "_wdata"}, bus_if.mst_wdata, 0);
    chk({tag, "_cmdrdy"}, bus_if.cmd_ready, 1);
    chk({tag, "_txrdy"}, bus_if.tx_ready, 0);
    chk({tag, "_rxvld"}, bus_if.rx_valid, 0);
    chk({tag, "_rxdata"}, bus_if.rx_data, 0);
    chk({tag, "_done"},  bus_if.done, 0);
    chk({tag, "_busy"},  bus_if.busy, 0);
  endtask

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_len = '0; bus_if.cmd_ss = '0; bus_if.cmd_cpol = 1'b0;
    bus_if.cmd_cpha = 1'b0; bus_if.cmd_div = '0;
    bus_if.mst_rdata = '0;
    repeat (3) step();
    chk_reset_outs("rst");
    rst = 1'b0;
    step();

    // basic single byte, SS=1 mode 0
    clear_logs();
    tx_src = '{8'hA5};
    start(8'd1, 2'd1, 1'b0, 1'b0, 16'd2);
    wait_done(1, 2000, "basic_done");
    chk("basic_nwr",   wr_a.size(), 4);
    chk("basic_w0a",   wa(0), A_SCDR);
    chk("basic_w0d",   wd(0), 32'h2);
    chk("basic_w1a",   wa(1), A_SPCR);
    chk("basic_w1d",   wd(1), 32'h140);
    chk("basic_w2a",   wa(2), A_SPDR);
    chk("basic_w2d",   wd(2), 32'hA5);
    chk("basic_w3a",   wa(3), A_SPCR);
    chk("basic_w3d",   wd(3), 32'h100);
    chk("basic_rx0",   rg(0), 32'hA5);
    chk("basic_nrx",   rx_got.size(), 1);
    step();
    chk("basic_pulse", done_cnt, 1);

    // long burst, SS=2 mode 3, in-flight limit
    clear_logs();
    for (int i = 0; i < 10; i++) tx_src.push_back(8'(i));
    start(8'd10, 2'd2, 1'b1, 1'b1, 16'd2);
    wait_done(1, 5000, "long_done");
    chk("long_spcr", wd(1), 32'h24C);
    chk("long_nrx",  rx_got.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("long_rx%0d", i), rg(i), 32'(i));
    chk("long_maxinfl", max_inflight, 4);

    // rx backpressure
    clear_logs();
    rx_rdy_en = 0;
    for (int i = 0; i < 6; i++) tx_src.push_back(8'h60 + 8'(i));
    start(8'd6, 2'd0, 1'b0, 1'b0, 16'd2);
    repeat (200) step();
    chk("bp_pushes", push_cnt, 4);
    chk("bp_rxvld",  bus_if.rx_valid, 1);
    chk("bp_rxdata", bus_if.rx_data, 32'h60);
    chk("bp_nrx",    rx_got.size(), 0);
    chk("bp_done0",  done_cnt, 0);
    rx_rdy_en = 1;
    wait_done(1, 5000, "bp_done");
    chk("bp_nrx6", rx_got.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_rx%0d", i), rg(i), 32'h60 + 32'(i));

    // zero-length command: done on the second cycle, no bus traffic
    step();
    clear_logs();
    start(8'd0, 2'd0, 1'b0, 1'b0, 16'd2);
    chk("zl_done_c1", bus_if.done, 0);
    chk("zl_busy_c1", bus_if.busy, 1);
    step();
    chk("zl_done_c2", bus_if.done, 1);
    step();
    chk("zl_done_c3", bus_if.done, 0);
    chk("zl_acc",     acc_cnt, 0);
    chk("zl_cnt",     done_cnt, 1);

    // reset during the third byte, then a clean LEN=2 burst
    clear_logs();
    for (int i = 0; i < 5; i++) tx_src.push_back(8'h50 + 8'(i));
    start(8'd5, 2'd1, 1'b0, 1'b0, 16'd2);
    begin
      int n = 0;
      while (push_cnt < 3 && n < 2000) begin step(); n++; end
    end
    chk("rm_reach3", push_cnt, 3);
    rst = 1'b1;
    step();
    chk_reset_outs("rm");
    rst = 1'b0;
    tx_src.delete();
    repeat (20) step();
    chk("rm_nodone", done_cnt, 0);
    clear_logs();
    tx_src = '{8'h31, 8'h32};
    start(8'd2, 2'd1, 1'b0, 1'b0, 16'd2);
    wait_done(1, 2000, "rm2_done");
    chk("rm2_nrx", rx_got.size(), 2);
    chk("rm2_rx0", rg(0), 32'h31);
    chk("rm2_rx1", rg(1), 32'h32);

`ifdef SPI_BURST_TIMEOUT_EN
    // no tx data: the watchdog abandons the burst
    step();
    clear_logs();
    err_with_done = 0;
    start(8'd3, 2'd0, 1'b0, 1'b0, 16'd2);
    wait_done(1, 70000, "to_done");
    step();
    chk("to_err_with_done", err_with_done, 1);
    chk("to_last_wa",   wa(wr_a.size() - 1), A_SPCR);
    chk("to_last_en",   wd(wr_d.size() - 1) & 32'h40, 0);
    chk("to_nrx",       rx_got.size(), 0);
`endif

    chk("model_ovf", m_ovf, 0);
    chk("model_unf", m_unf, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
